bcd_dec_serializer: RTL

Parametrised, sequential successor to the team's single-digit BCD-to-decimal one-hot decoder. Accepts a packed multi-digit BCD word over a valid/ready handshake. Emits one full 10-way one-hot decimal decode per digit, most-significant digit first, over a valid/ready output. Adds invalid-code detection with a sticky error flag and optional leading-zero blanking. Sits between BCD counters/arithmetic and display or indicator drivers.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_onehot_dec.sv | 29 ++
 rtl/bcd_dec_serializer.sv | 112 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, state encoding and index-width helper for
//                the BCD decode/serialize block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int NUM_DEC = 10;
    localparam int BCD_MAX = 9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Digit index width, never narrower than one bit so DIGITS=1 still has a port.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_onehot_dec.sv
// ============================================================================
//  Module      : bcd_onehot_dec
//  Description : Combinational 4-bit BCD to 10-way one-hot decoder with an
//                invalid-code flag for codes 10..15.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_onehot_dec
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0]   bcd_i,
    output logic [NUM_DEC-1:0] onehot_o,
    output logic               invalid_o
);

    always_comb begin
        onehot_o  = '0;
        invalid_o = 1'b0;
        if (bcd_i > BCD_W'(BCD_MAX)) begin
            invalid_o = 1'b1;
        end else begin
            onehot_o = NUM_DEC'(1) << bcd_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_dec_serializer.sv
// ============================================================================
//  Module      : bcd_dec_serializer
//  Description : Accepts a packed multi-digit BCD word and emits one one-hot
//                decimal decode per digit, MSD first, with optional leading-
//                zero blanking and sticky invalid-code detection.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_dec_serializer
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int IDXW   = idx_w(DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BCD_W*DIGITS-1:0] in_bcd,
    input  logic                    blank_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_DEC-1:0]      out_onehot,
    output logic [IDXW-1:0]         out_idx,
    output logic                    out_last,
    output logic                    out_err,
    output logic                    err_sticky,
    input  logic                    err_clr
);

    state_t                  state_q;
    logic [BCD_W*DIGITS-1:0] word_q;
    logic [IDXW-1:0]         idx_q;
    logic                    blank_q;
    logic                    err_sticky_q;

    logic [BCD_W-1:0]        w_digit;
    logic [NUM_DEC-1:0]      w_dec;
    logic                    w_invalid;
    logic                    w_busy;
    logic                    w_last;
    logic                    w_blank_now;
    logic                    w_accept;
    logic                    w_xfer;

    always_comb begin
        w_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                w_digit = word_q[i*BCD_W +: BCD_W];
            end
        end
    end

    bcd_onehot_dec u_dec (
        .bcd_i     (w_digit),
        .onehot_o  (w_dec),
        .invalid_o (w_invalid)
    );

    assign w_busy      = (state_q == ST_BUSY);
    assign w_last      = w_busy && (idx_q == '0);
    assign w_xfer      = w_busy && out_ready;
    // Ready during the final beat lets the next word load with no bubble.
    assign in_ready    = !w_busy || (out_ready && w_last);
    assign w_accept    = in_valid && in_ready;
    assign w_blank_now = blank_q && (w_digit == '0) && (idx_q != '0);

    assign out_valid   = w_busy;
    assign out_onehot  = (w_busy && !w_blank_now) ? w_dec : '0;
    assign out_err     = w_busy && w_invalid;
    assign out_idx     = idx_q;
    assign out_last    = w_last;
    assign err_sticky  = err_sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            idx_q        <= '0;
            blank_q      <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            if (w_xfer && out_err) begin
                err_sticky_q <= 1'b1;
            end else if (err_clr) begin
                err_sticky_q <= 1'b0;
            end

            if (w_accept) begin
                word_q  <= in_bcd;
                blank_q <= blank_en;
                idx_q   <= IDXW'(DIGITS - 1);
                state_q <= ST_BUSY;
            end else if (w_xfer) begin
                if (w_last) begin
                    state_q <= ST_IDLE;
                end else begin
                    idx_q <= idx_q - IDXW'(1);
                end
                // Any nonzero code, valid or not, ends the leading-zero run.
                if (w_digit != '0) begin
                    blank_q <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire
